// File: rtl/enqueue_pkg.sv
// Shared types and default sizing for the deserializer-to-queue enqueue controller.
package enqueue_pkg;

    localparam int unsigned DataWDef         = 8;
    localparam int unsigned LenWDef          = 4;
    localparam int unsigned DepthDef         = 8;
    localparam int unsigned FullWaitTicksDef = 16;
    localparam int unsigned ConfirmTicksDef  = 2;
    localparam int unsigned CntWDef          = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        ENQ,
        CONFIRM,
        DROP,
        ACK
    } state_t;

endpackage

// File: rtl/enqueue_ctrl_tick_timer.sv
// Tick-gated up-counter with synchronous clear; hit_o flags the tick that reaches limit_i.
module tick_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         tick_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && tick_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = en_i && tick_i && ((count_q + 1'b1) == limit_i);

endmodule

// File: rtl/enqueue_ctrl.sv
// Moves one deserializer word into a tick-paced queue, confirms it via the queue length,
// drops and counts words that cannot be placed, and closes a 4-phase ack handshake.
module enqueue_ctrl
    import enqueue_pkg::*;
#(
    parameter int unsigned DATA_W          = DataWDef,
    parameter int unsigned LEN_W           = LenWDef,
    parameter int unsigned DEPTH           = DepthDef,
    parameter int unsigned FULL_WAIT_TICKS = FullWaitTicksDef,
    parameter int unsigned CONFIRM_TICKS   = ConfirmTicksDef,
    parameter int unsigned CNT_W           = CntWDef
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_in,
    input  logic              des_ready_in,
    input  logic [DATA_W-1:0] des_data_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              deq_in,
    output logic              enq_out,
    output logic [DATA_W-1:0] enq_data_out,
    output logic              ack_out,
    output logic              busy_out,
    output logic              drop_out,
    output logic [CNT_W-1:0]  drop_cnt_out
);

    localparam int unsigned MaxTicks = (FULL_WAIT_TICKS > CONFIRM_TICKS) ?
                                       FULL_WAIT_TICKS : CONFIRM_TICKS;
    localparam int unsigned TmrW     = $clog2(MaxTicks + 1);
    localparam logic [LEN_W:0] DepthX = (LEN_W + 1)'(DEPTH);

    state_t              state_q;
    logic                enq_q, ack_q, busy_q, drop_q, deq_seen_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    drop_cnt_q;
    logic [LEN_W-1:0]    len_snap_q;

    logic                has_room, len_match, tmr_clr, tmr_en, tmr_hit;
    logic [LEN_W:0]      exp_len;
    logic [TmrW-1:0]     tmr_limit;

    assign has_room = {1'b0, len_in} < DepthX;

    // One extra bit so DEPTH-1 + 1 does not wrap before the compare.
    assign exp_len   = {1'b0, len_snap_q} + (LEN_W + 1)'(1)
                     - {{LEN_W{1'b0}}, (deq_seen_q && (len_snap_q != '0))};
    assign len_match = ({1'b0, len_in} == exp_len);

    always_comb begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE:      tmr_clr = 1'b1;
            WAIT_SLOT: tmr_en  = des_ready_in && !has_room;
            ENQ:       tmr_clr = 1'b1;
            CONFIRM:   tmr_en  = !len_match;
            default:   ;
        endcase
    end

    assign tmr_limit = (state_q == WAIT_SLOT) ? TmrW'(FULL_WAIT_TICKS) : TmrW'(CONFIRM_TICKS);

    tick_timer #(
        .W (TmrW)
    ) u_timer (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .tick_i  (tick_in),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            enq_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            deq_seen_q <= 1'b0;
            data_q     <= '0;
            drop_cnt_q <= '0;
            len_snap_q <= '0;
        end else begin
            drop_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (des_ready_in) begin
                        data_q  <= des_data_in;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (!des_ready_in) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tick_in) begin
                        if (has_room) begin
                            enq_q   <= 1'b1;
                            state_q <= ENQ;
                        end else if (tmr_hit) begin
                            drop_q  <= 1'b1;
                            state_q <= DROP;
                            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                        end
                    end
                end
                ENQ: begin
                    if (tick_in) begin
                        len_snap_q <= len_in;
                        deq_seen_q <= deq_in;
                        enq_q      <= 1'b0;
                        state_q    <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (tick_in) begin
                        if (len_match) begin
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end else if (tmr_hit) begin
                            drop_q  <= 1'b1;
                            state_q <= DROP;
                            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                        end
                    end
                end
                DROP: begin
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!des_ready_in) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    enq_q   <= 1'b0;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign enq_out      = enq_q;
    assign enq_data_out = data_q;
    assign ack_out      = ack_q;
    assign busy_out     = busy_q;
    assign drop_out     = drop_q;
    assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_enqueue_ctrl.sv
// Bench for enqueue_ctrl: directed vector table, hand-written corner sequences and random
// transfers scored against an outcome model of the transfer rules.
module tb_enqueue_ctrl;

    localparam int Depth     = 8;
    localparam int FullWait  = 16;
    localparam int CntMax    = 255;
    localparam int TxnBudget = 3000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       des_ready_in = 1'b0;
    logic [7:0] des_data_in = '0;
    logic [3:0] len_in = '0;
    logic       deq_in = 1'b0;
    logic       enq_out, ack_out, busy_out, drop_out;
    logic [7:0] enq_data_out, drop_cnt_out;

    enqueue_ctrl #(
        .DATA_W          (8),
        .LEN_W           (4),
        .DEPTH           (8),
        .FULL_WAIT_TICKS (16),
        .CONFIRM_TICKS   (2),
        .CNT_W           (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick_in      (tick_in),
        .des_ready_in (des_ready_in),
        .des_data_in  (des_data_in),
        .len_in       (len_in),
        .deq_in       (deq_in),
        .enq_out      (enq_out),
        .enq_data_out (enq_data_out),
        .ack_out      (ack_out),
        .busy_out     (busy_out),
        .drop_out     (drop_out),
        .drop_cnt_out (drop_cnt_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    typedef struct {
        logic [7:0] data;
        int         len_room;
        int         full_ticks;
        bit         deq;
        bit         stuck;
        int         period;
        bit         exp_enq;
        bit         exp_drop;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int outs_packed();
        return int'({enq_out, ack_out, busy_out, drop_out, enq_data_out, drop_cnt_out});
    endfunction

    // Acts as deserializer and queue for one word; tallies what the DUT did.
    task automatic run_txn(input logic [7:0] data, input int len_room, input int full_ticks,
                           input bit deq, input bit stuck, input int period,
                           input bit exp_enq, input bit exp_drop, input string tag);
        int enq_ticks = 0, drops = 0, full_seen = 0, edges = 0, first_enq = -1;
        int new_len = 0, hold = 0;
        logic [7:0] seen = '0;
        bit accepted = 0, applied = 0, ack_seen = 0, ack_gap = 0, done = 0, over = 0;
        hold = int'($urandom_range(0, 2));
        len_in = (full_ticks > 0) ? 4'(Depth) : 4'(len_room);
        des_data_in = data;
        des_ready_in = 1'b1;
        for (int cyc = 0; cyc < TxnBudget; cyc++) begin
            if (ack_seen && !des_ready_in && !busy_out && !ack_out) begin
                done = 1;
                break;
            end
            tick_in = ((cyc % period) == (period - 1));
            deq_in = 1'b0;
            if (enq_out) begin
                if (first_enq < 0) first_enq = edges;
                if (tick_in) begin
                    enq_ticks++;
                    seen = enq_data_out;
                    accepted = 1;
                    deq_in = deq;
                    if (int'(len_in) >= Depth) over = 1;
                    new_len = stuck ? int'(len_in)
                                    : int'(len_in) + 1 - ((deq && len_in != 0) ? 1 : 0);
                end
            end
            if (drop_out) drops++;
            if (ack_seen && des_ready_in && !ack_out) ack_gap = 1;
            if (ack_out) ack_seen = 1;
            if (ack_seen && des_ready_in) begin
                if (hold == 0) des_ready_in = 1'b0;
                else hold--;
            end
            if (tick_in && busy_out && !accepted && drops == 0 && int'(len_in) == Depth)
                full_seen++;
            step();
            edges++;
            if (accepted && !applied) begin
                len_in = 4'(new_len);
                applied = 1;
            end else if (full_ticks > 0 && full_seen == full_ticks && !accepted &&
                         int'(len_in) == Depth) begin
                len_in = 4'(len_room);
            end
        end
        tick_in = 1'b0;
        deq_in = 1'b0;
        des_ready_in = 1'b0;
        if (exp_drop && model_cnt < CntMax) model_cnt++;
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_enq_ticks"}, enq_ticks, int'(exp_enq));
        if (exp_enq) check({tag, "_enq_data"}, int'(seen), int'(data));
        check({tag, "_drop_pulses"}, drops, int'(exp_drop));
        check({tag, "_ack"}, int'(ack_seen), 1);
        check({tag, "_ack_held"}, int'(ack_gap), 0);
        check({tag, "_over_depth"}, int'(over), 0);
        check({tag, "_drop_cnt"}, int'(drop_cnt_out), model_cnt);
        if (period == 1 && full_ticks == 0) check({tag, "_latency"}, first_enq, 2);
        step();
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'hA5, 2, 0,  1'b0, 1'b0, 10, 1'b1, 1'b0};  // normal transfer
        vecs[1] = '{8'h3C, 0, 16, 1'b0, 1'b0, 3,  1'b0, 1'b1};  // full too long
        vecs[2] = '{8'h5A, 4, 0,  1'b1, 1'b1, 2,  1'b1, 1'b0};  // deq cancels bump
        vecs[3] = '{8'hC3, 5, 0,  1'b0, 1'b1, 1,  1'b1, 1'b1};  // length stuck
        vecs[4] = '{8'h7E, 7, 0,  1'b0, 1'b0, 1,  1'b1, 1'b0};  // DEPTH-1 is not full
        vecs[5] = '{8'h81, 3, 15, 1'b0, 1'b0, 2,  1'b1, 1'b0};  // room on the 16th tick
        vecs[6] = '{8'h42, 0, 0,  1'b1, 1'b1, 1,  1'b1, 1'b1};  // empty: deq ignored
        vecs[7] = '{8'h18, 0, 0,  1'b1, 1'b0, 4,  1'b1, 1'b0};

        repeat (3) step();
        check("reset_outputs", outs_packed(), 0);
        reset = 1'b1;
        step();
        check("idle_after_reset", outs_packed(), 0);

        foreach (vecs[i])
            run_txn(vecs[i].data, vecs[i].len_room, vecs[i].full_ticks, vecs[i].deq,
                    vecs[i].stuck, vecs[i].period, vecs[i].exp_enq, vecs[i].exp_drop,
                    $sformatf("vec%0d", i));

        // Reset asserted while the enqueue is outstanding.
        len_in = 4'd2;
        des_data_in = 8'h77;
        des_ready_in = 1'b1;
        step();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        check("midenq_enq_high", int'(enq_out), 1);
        reset = 1'b0;
        des_ready_in = 1'b0;
        step();
        check("midenq_reset_outs", outs_packed(), 0);
        bad = 0;
        repeat (2) begin
            step();
            if (enq_out || busy_out) bad++;
        end
        reset = 1'b1;
        repeat (3) begin
            step();
            if (enq_out || busy_out) bad++;
        end
        check("midenq_no_enq_after", bad, 0);
        model_cnt = 0;

        // Deserializer withdraws while the queue is full.
        len_in = 4'(Depth);
        des_data_in = 8'h99;
        des_ready_in = 1'b1;
        bad = 0;
        step();
        check("abort_busy", int'(busy_out), 1);
        tick_in = 1'b1;
        repeat (2) begin
            step();
            if (enq_out || ack_out || drop_out) bad++;
        end
        tick_in = 1'b0;
        des_ready_in = 1'b0;
        step();
        check("abort_idle", int'(busy_out), 0);
        repeat (5) begin
            step();
            if (enq_out || ack_out || drop_out || busy_out) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_cnt", int'(drop_cnt_out), model_cnt);

        for (int n = 0; n < 40; n++) begin
            int full, lr, per;
            bit dq, st, ee, ed;
            full = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
            lr   = int'($urandom_range(0, Depth - 1));
            per  = int'($urandom_range(1, 4));
            dq   = 1'($urandom_range(0, 1));
            st   = 1'($urandom_range(0, 1));
            ee   = (full < FullWait);
            // A stuck length still confirms when a dequeue cancels the expected bump.
            ed   = !ee || (st && !(dq && lr != 0));
            run_txn(8'($urandom), lr, full, dq, st, per, ee, ed, $sformatf("rnd%0d", n));
        end

        while (model_cnt < CntMax) run_txn(8'($urandom), 5, 0, 1'b0, 1'b1, 1, 1'b1, 1'b1, "fill");
        run_txn(8'hEE, 5, 0, 1'b0, 1'b1, 1, 1'b1, 1'b1, "saturate");
        check("cnt_saturated", int'(drop_cnt_out), CntMax);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
